hazard_ctrl: RTL

- Parametrised hazard and forwarding controller for the Riscv151 pipeline, generalised to configurable depth.
- Tracks every in-flight instruction past I in a scoreboard shift register and produces per-operand forwarding selects.
- Handles load-use stalls, taken-branch/jump kills, and whole-pipe freeze on data-cache backpressure.
- Sits beside `control`. Decode fields come from I. Branch resolution comes from X. `mem_ready` comes from the data cache.

---
 rtl/hazard_pkg.sv | 45 ++++
 rtl/hazard_sb_entry.sv | 27 ++
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller: select encoding,
// scoreboard entry bit layout, parameter legality checks and control modes.
package hazard_pkg;

   localparam int FWD_SEL_REGFILE = 0;

   // Scoreboard entry layout, LSB first: rd[aw-1:0], is_load, we, valid.
   localparam int SB_RD_LSB = 0;

   function automatic int sb_load_bit(input int aw);
      return aw;
   endfunction

   function automatic int sb_we_bit(input int aw);
      return aw + 32'sd1;
   endfunction

   function automatic int sb_valid_bit(input int aw);
      return aw + 32'sd2;
   endfunction

   function automatic int sb_width(input int aw);
      return aw + 32'sd3;
   endfunction

   function automatic bit num_stages_legal(input int n);
      return (n >= 32'sd3) && (n <= 32'sd6);
   endfunction

   function automatic bit load_lat_legal(input int lat, input int n);
      return (lat >= 32'sd1) && (lat <= n - 32'sd2);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_FLUSH      = 2'd2,
      HZ_FREEZE     = 2'd3
   } hz_mode_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: holds while the pipe is frozen, otherwise loads the
// previous slot's contents or an all-zero (invalid) bubble.
module hazard_sb_entry
   import hazard_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         advance,
   input  logic         bubble,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Slot register with hold / bubble / advance control.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (advance) begin
         q <= bubble ? '0 : d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a NUM_STAGES-deep pipeline.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush/freeze counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter  int NUM_STAGES = 3,
   parameter  int REG_ADDR_W = 5,
   parameter  int LOAD_LAT   = 1,
   localparam int SEL_W      = $clog2(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_we,
   input  logic                  id_is_load,
   input  logic                  br_taken,
   input  logic                  mem_ready,
   output logic                  stall_I,
   output logic                  flush_I,
   output logic [SEL_W-1:0]      fwd_a_sel,
   output logic [SEL_W-1:0]      fwd_b_sel,
   output logic                  bubble_X
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           perf_stall_cnt,
   output logic [31:0]           perf_flush_cnt,
   output logic [31:0]           perf_freeze_cnt
`endif
);

   localparam int NE = NUM_STAGES - 1;
   localparam int EW = sb_width(REG_ADDR_W);
   localparam int VB = sb_valid_bit(REG_ADDR_W);
   localparam int WB = sb_we_bit(REG_ADDR_W);
   localparam int LB = sb_load_bit(REG_ADDR_W);

   if (!num_stages_legal(NUM_STAGES) || !load_lat_legal(LOAD_LAT, NUM_STAGES)) begin : g_bad_params
      $error("hazard_ctrl: illegal NUM_STAGES/LOAD_LAT combination");
   end

   logic [NE:1][EW-1:0] sb_q;
   logic [EW-1:0]       id_entry;
   logic                head_bubble;
   logic [SEL_W-1:0]    sel_a;
   logic [SEL_W-1:0]    sel_b;
   logic                lu_a;
   logic                lu_b;
   logic                load_use;
   hz_mode_e            mode;

   function automatic logic sb_match(input logic [EW-1:0] e,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic used);
      logic [REG_ADDR_W-1:0] rd;
      rd = e[SB_RD_LSB +: REG_ADDR_W];
      return e[VB] && e[WB] && used && (rd != '0) && (rd == rs);
   endfunction

   assign id_entry = {id_valid, id_we, id_is_load, id_rd};

   // A freeze holds every slot; X only takes I's fields when I is real and survives.
   assign head_bubble = (mode == HZ_LOAD_STALL) || (mode == HZ_FLUSH) || !id_valid;

   for (genvar k = 1; k <= NE; k++) begin : g_sb
      if (k == 1) begin : g_head
         hazard_sb_entry #(.W(EW)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .advance (mem_ready),
            .bubble  (head_bubble),
            .d       (id_entry),
            .q       (sb_q[k])
         );
      end else begin : g_tail
         hazard_sb_entry #(.W(EW)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .advance (mem_ready),
            .bubble  (1'b0),
            .d       (sb_q[k-1]),
            .q       (sb_q[k])
         );
      end
   end

   // Youngest matching producer per operand; scanning oldest-first lets the youngest overwrite.
   always_comb begin
      sel_a = SEL_W'(FWD_SEL_REGFILE);
      sel_b = SEL_W'(FWD_SEL_REGFILE);
      lu_a  = 1'b0;
      lu_b  = 1'b0;
      for (int k = NE; k >= 1; k--) begin
         if (sb_match(sb_q[k], id_rs1, id_rs1_used)) begin
            sel_a = SEL_W'(k);
            lu_a  = sb_q[k][LB] && (k <= LOAD_LAT);
         end else begin
            sel_a = sel_a;
         end
         if (sb_match(sb_q[k], id_rs2, id_rs2_used)) begin
            sel_b = SEL_W'(k);
            lu_b  = sb_q[k][LB] && (k <= LOAD_LAT);
         end else begin
            sel_b = sel_b;
         end
      end
   end

   assign load_use = id_valid && (lu_a || lu_b);

   // Control mode: freeze beats branch kill, which beats load-use; reset masks all.
   always_comb begin
      mode = HZ_RUN;
      if (reset) begin
         mode = HZ_RUN;
      end else if (!mem_ready) begin
         mode = HZ_FREEZE;
      end else if (br_taken) begin
         mode = HZ_FLUSH;
      end else if (load_use) begin
         mode = HZ_LOAD_STALL;
      end else begin
         mode = HZ_RUN;
      end
   end

   // Decode the mode into the pipeline control strobes.
   always_comb begin
      stall_I  = 1'b0;
      flush_I  = 1'b0;
      bubble_X = 1'b0;
      case (mode)
         HZ_RUN: begin
            stall_I = 1'b0;
         end
         HZ_LOAD_STALL: begin
            stall_I  = 1'b1;
            bubble_X = 1'b1;
         end
         HZ_FLUSH: begin
            flush_I = 1'b1;
         end
         HZ_FREEZE: begin
            stall_I = 1'b1;
         end
         default: begin
            stall_I  = 1'b0;
            flush_I  = 1'b0;
            bubble_X = 1'b0;
         end
      endcase
   end

   assign fwd_a_sel = reset ? SEL_W'(FWD_SEL_REGFILE) : sel_a;
   assign fwd_b_sel = reset ? SEL_W'(FWD_SEL_REGFILE) : sel_b;

`ifdef HAZARD_PERF_EN
   // Saturating event counters, one increment per qualifying cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cnt  <= 32'd0;
         perf_flush_cnt  <= 32'd0;
         perf_freeze_cnt <= 32'd0;
      end else begin
         perf_stall_cnt  <= sat_inc(perf_stall_cnt,  mode == HZ_LOAD_STALL);
         perf_flush_cnt  <= sat_inc(perf_flush_cnt,  mode == HZ_FLUSH);
         perf_freeze_cnt <= sat_inc(perf_freeze_cnt, mode == HZ_FREEZE);
      end
   end
`endif

endmodule
